// File: rtl/pattern_stream_pkg.sv
// Shared types and defaults for the pattern stream source.
package pattern_stream_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam word_t DEFAULT_PATTERN [4] = '{32'd3, 32'd5, 32'd7, 32'd11};

endpackage

// File: rtl/pattern_lookup.sv
// Combinational table lookup: returns PATTERN[idx] + offset, carry dropped.
module pattern_lookup
    import pattern_stream_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int IW    = 2,
    parameter logic [WIDTH-1:0] PATTERN [DEPTH] = DEFAULT_PATTERN
) (
    input  logic [IW-1:0]    idx,
    input  logic [WIDTH-1:0] offset,
    output logic [WIDTH-1:0] word
);

    assign word = PATTERN[idx] + offset;

endmodule

// File: rtl/pattern_stream_src.sv
// Walks a parameterised pattern table and emits PATTERN[i] + captured offset
// as a registered valid/ready stream, one-shot or looping.
module pattern_stream_src
    import pattern_stream_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] PATTERN [DEPTH] = DEFAULT_PATTERN,
    parameter logic LOOP = 1'b0,
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_x,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW-1:0]    idx,
    output logic             busy,
    output logic             done
);

    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    state_t           state;
    logic [WIDTH-1:0] offset_q;
    logic [IW-1:0]    sel_idx;
    logic [WIDTH-1:0] sel_offset;
    logic [WIDTH-1:0] next_word;
    logic             last;
    logic             xfer;

    assign last = (idx == LAST_IDX);
    assign xfer = out_valid & out_ready;

    // In IDLE the lookup sees the live in_x so the first word is ready on the
    // capture edge; afterwards it sees the held offset and the next index.
    always_comb begin
        sel_idx    = '0;
        sel_offset = offset_q;
        if (state == IDLE) begin
            sel_offset = in_x;
        end else if (!last) begin
            sel_idx = idx + IW'(1);
        end
    end

    pattern_lookup #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .IW      (IW),
        .PATTERN (PATTERN)
    ) u_lookup (
        .idx    (sel_idx),
        .offset (sel_offset),
        .word   (next_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            offset_q  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        offset_q  <= in_x;
                        idx       <= '0;
                        out_data  <= next_word;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (!last) begin
                            idx      <= sel_idx;
                            out_data <= next_word;
                        end else if (LOOP) begin
                            idx      <= '0;
                            out_data <= next_word;
                        end else begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_stream_src.sv
// Directed bench for pattern_stream_src: one-shot, backpressure, loop, wrap,
// ignored starts, DEPTH=1 and asynchronous reset.
module tb_pattern_stream_src;

    localparam logic [31:0] PAT_WRAP [4] = '{32'hFFFF_FFFF, 32'd5, 32'd7, 32'd11};
    localparam logic [31:0] PAT_ONE  [1] = '{32'd9};

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start0 = 0, ready0 = 1, valid0, busy0, done0;
    logic [31:0] in_x0 = 0, data0;
    logic [1:0]  idx0;

    logic        start1 = 0, ready1 = 1, valid1, busy1, done1;
    logic [31:0] in_x1 = 0, data1;
    logic [1:0]  idx1;

    logic        start2 = 0, ready2 = 1, valid2, busy2, done2;
    logic [31:0] in_x2 = 0, data2;
    logic [1:0]  idx2;

    logic        start3 = 0, ready3 = 1, valid3, busy3, done3;
    logic [31:0] in_x3 = 0, data3;
    logic        idx3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pattern_stream_src #(.WIDTH(32), .DEPTH(4), .LOOP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .in_x(in_x0), .out_data(data0),
        .out_valid(valid0), .out_ready(ready0), .idx(idx0), .busy(busy0), .done(done0));

    pattern_stream_src #(.WIDTH(32), .DEPTH(4), .LOOP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .in_x(in_x1), .out_data(data1),
        .out_valid(valid1), .out_ready(ready1), .idx(idx1), .busy(busy1), .done(done1));

    pattern_stream_src #(.WIDTH(32), .DEPTH(4), .PATTERN(PAT_WRAP), .LOOP(1'b0)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .in_x(in_x2), .out_data(data2),
        .out_valid(valid2), .out_ready(ready2), .idx(idx2), .busy(busy2), .done(done2));

    pattern_stream_src #(.WIDTH(32), .DEPTH(1), .PATTERN(PAT_ONE), .LOOP(1'b0)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .in_x(in_x3), .out_data(data3),
        .out_valid(valid3), .out_ready(ready3), .idx(idx3), .busy(busy3), .done(done3));

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({data0, valid0, idx0, busy0, done0} !== 37'd0) begin
            failures++;
            $display("FAIL reset_dut0 got data=%0d valid=%b idx=%0d busy=%b done=%b exp all 0",
                     data0, valid0, idx0, busy0, done0);
        end
        checks++;
        if ({valid1, busy1, done1, valid2, valid3} !== 5'd0) begin
            failures++;
            $display("FAIL reset_others got %b exp 00000", {valid1, busy1, done1, valid2, valid3});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_one_shot();
        logic [31:0] exp_w [4] = '{32'd6, 32'd8, 32'd10, 32'd14};
        in_x0 = 32'd3; ready0 = 1'b1; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (valid0 !== 1'b1 || data0 !== exp_w[k] || idx0 !== 2'(k) || busy0 !== 1'b1) begin
                failures++;
                $display("FAIL one_shot_w%0d got valid=%b data=%0d idx=%0d busy=%b exp 1/%0d/%0d/1",
                         k, valid0, data0, idx0, busy0, exp_w[k], k);
            end
            @(negedge clk);
        end
        checks++;
        if (done0 !== 1'b1 || valid0 !== 1'b0 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL one_shot_done got done=%b valid=%b busy=%b exp 1/0/0", done0, valid0, busy0);
        end
        @(negedge clk);
        checks++;
        if (done0 !== 1'b0 || busy0 !== 1'b0 || data0 !== 32'd14) begin
            failures++;
            $display("FAIL one_shot_after got done=%b busy=%b data=%0d exp 0/0/14", done0, busy0, data0);
        end
    endtask

    task automatic test_backpressure();
        in_x0 = 32'd3; ready0 = 1'b1; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        ready0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (valid0 !== 1'b1 || data0 !== 32'd8 || idx0 !== 2'd1) begin
                failures++;
                $display("FAIL bp_hold%0d got valid=%b data=%0d idx=%0d exp 1/8/1", k, valid0, data0, idx0);
            end
        end
        ready0 = 1'b1;
        @(negedge clk);
        checks++;
        if (data0 !== 32'd10 || idx0 !== 2'd2) begin
            failures++;
            $display("FAIL bp_w2 got data=%0d idx=%0d exp 10/2", data0, idx0);
        end
        @(negedge clk);
        checks++;
        if (data0 !== 32'd14 || idx0 !== 2'd3) begin
            failures++;
            $display("FAIL bp_w3 got data=%0d idx=%0d exp 14/3", data0, idx0);
        end
        @(negedge clk);
        checks++;
        if (done0 !== 1'b1) begin
            failures++;
            $display("FAIL bp_done got done=%b exp 1", done0);
        end
        @(negedge clk);
    endtask

    task automatic test_loop();
        logic [31:0] exp_w [10] = '{3, 5, 7, 11, 3, 5, 7, 11, 3, 5};
        in_x1 = 32'd0; ready1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (valid1 !== 1'b1 || data1 !== exp_w[k] || done1 !== 1'b0 || busy1 !== 1'b1) begin
                failures++;
                $display("FAIL loop_w%0d got valid=%b data=%0d done=%b busy=%b exp 1/%0d/0/1",
                         k, valid1, data1, done1, busy1, exp_w[k]);
            end
            @(negedge clk);
        end
        checks++;
        if (idx1 !== 2'd2) begin
            failures++;
            $display("FAIL loop_idx got %0d exp 2", idx1);
        end
    endtask

    task automatic test_wrap();
        in_x2 = 32'd2; ready2 = 1'b1; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        checks++;
        if (valid2 !== 1'b1 || data2 !== 32'h0000_0001) begin
            failures++;
            $display("FAIL wrap_w0 got valid=%b data=%h exp 1/00000001", valid2, data2);
        end
        @(negedge clk);
        checks++;
        if (data2 !== 32'd7 || idx2 !== 2'd1) begin
            failures++;
            $display("FAIL wrap_w1 got data=%0d idx=%0d exp 7/1", data2, idx2);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (busy2 !== 1'b0 || valid2 !== 1'b0) begin
            failures++;
            $display("FAIL wrap_end got busy=%b valid=%b exp 0/0", busy2, valid2);
        end
    endtask

    task automatic test_depth_one();
        in_x3 = 32'd1; ready3 = 1'b0; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        @(negedge clk);
        checks++;
        if (valid3 !== 1'b1 || data3 !== 32'd10 || idx3 !== 1'b0) begin
            failures++;
            $display("FAIL d1_word got valid=%b data=%0d idx=%b exp 1/10/0", valid3, data3, idx3);
        end
        ready3 = 1'b1;
        @(negedge clk);
        checks++;
        if (done3 !== 1'b1 || valid3 !== 1'b0 || busy3 !== 1'b0) begin
            failures++;
            $display("FAIL d1_done got done=%b valid=%b busy=%b exp 1/0/0", done3, valid3, busy3);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        in_x0 = 32'd3; ready0 = 1'b1; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (idx0 !== 2'd2 || data0 !== 32'd10) begin
            failures++;
            $display("FAIL ign_pre got idx=%0d data=%0d exp 2/10", idx0, data0);
        end
        start0 = 1'b1;
        in_x0 = 32'd100;
        @(negedge clk);
        start0 = 1'b0;
        checks++;
        if (idx0 !== 2'd3 || data0 !== 32'd14) begin
            failures++;
            $display("FAIL ign_run got idx=%0d data=%0d exp 3/14", idx0, data0);
        end
        @(negedge clk);
        checks++;
        if (done0 !== 1'b1) begin
            failures++;
            $display("FAIL ign_done got done=%b exp 1", done0);
        end
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        in_x0 = 32'd3;
        @(negedge clk);
        checks++;
        if (valid0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
            failures++;
            $display("FAIL ign_done_start got valid=%b busy=%b done=%b exp 0/0/0", valid0, busy0, done0);
        end
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        checks++;
        if (valid0 !== 1'b1 || data0 !== 32'd6 || idx0 !== 2'd0) begin
            failures++;
            $display("FAIL ign_restart got valid=%b data=%0d idx=%0d exp 1/6/0", valid0, data0, idx0);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_async_reset();
        in_x0 = 32'd3; ready0 = 1'b1; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (idx0 !== 2'd2 || valid0 !== 1'b1) begin
            failures++;
            $display("FAIL arst_pre got idx=%0d valid=%b exp 2/1", idx0, valid0);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({data0, valid0, idx0, busy0, done0} !== 37'd0) begin
            failures++;
            $display("FAIL arst_now got data=%0d valid=%b idx=%0d busy=%b done=%b exp all 0",
                     data0, valid0, idx0, busy0, done0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (done0 !== 1'b0 || valid0 !== 1'b0) begin
            failures++;
            $display("FAIL arst_idle got done=%b valid=%b exp 0/0", done0, valid0);
        end
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        checks++;
        if (valid0 !== 1'b1 || data0 !== 32'd6 || idx0 !== 2'd0) begin
            failures++;
            $display("FAIL arst_restart got valid=%b data=%0d idx=%0d exp 1/6/0", valid0, data0, idx0);
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_backpressure();
        test_loop();
        test_wrap();
        test_depth_one();
        test_start_ignored();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
